// File: rtl/am_eval_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
// Holds the FSM state encoding and the per-sample stage-1 result record.
package am_eval_pkg;

  localparam int OPER_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Stage-1 result for one sample; sdiff is z_approx - exact product.
  typedef struct packed {
    logic [PROD_W-1:0]        prod;
    logic [PROD_W-1:0]        abs_diff;
    logic signed [PROD_W:0]   sdiff;
  } diff_t;

endpackage

// File: rtl/am_error_monitor_if.sv
// Sample stream between the stimulus source and the error monitor:
// operands, the approximate product, and a valid/ready handshake.
interface am_error_monitor_if;
  import am_eval_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPER_W-1:0] x;
  logic [OPER_W-1:0] y;
  logic [PROD_W-1:0] z_approx;

  modport master (output in_valid, x, y, z_approx, input in_ready);
  modport slave  (input in_valid, x, y, z_approx, output in_ready);

endinterface

// File: rtl/am_abs_diff.sv
// Stage-1 datapath: exact product of x and y, the signed error of the
// approximate product against it, and the error magnitude.
module am_abs_diff
  import am_eval_pkg::*;
(
  input  logic [OPER_W-1:0] x,
  input  logic [OPER_W-1:0] y,
  input  logic [PROD_W-1:0] z_approx,
  output diff_t             res
);

  logic [PROD_W-1:0]      prod;
  logic signed [PROD_W:0] sdiff;
  logic [PROD_W:0]        neg_sdiff;

  always_comb begin
    prod      = PROD_W'(x) * PROD_W'(y);
    sdiff     = $signed({1'b0, z_approx}) - $signed({1'b0, prod});
    neg_sdiff = -sdiff;
    res.prod     = prod;
    res.sdiff    = sdiff;
    // Magnitude never exceeds 65535, so the top bit of the negation is dropped.
    res.abs_diff = sdiff[PROD_W] ? neg_sdiff[PROD_W-1:0] : sdiff[PROD_W-1:0];
  end

endmodule

// File: rtl/am_error_monitor.sv
// Accumulates error statistics of an approximate 8x8 multiplier over a run
// of 2^LOG2_SAMPLES samples: capture, stage-1 difference, stage-2 accumulate.
module am_error_monitor
  import am_eval_pkg::*;
#(
  parameter int LOG2_SAMPLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  am_error_monitor_if.slave               smp,
  output logic                            busy,
  output logic                            done,
  output logic [16+LOG2_SAMPLES-1:0]      sum_ed,
  output logic signed [17+LOG2_SAMPLES-1:0] sum_bias,
  output logic [PROD_W-1:0]               max_ed,
  output logic [LOG2_SAMPLES:0]           err_cnt
);

  localparam int ED_W   = PROD_W + LOG2_SAMPLES;
  localparam int BIAS_W = PROD_W + 1 + LOG2_SAMPLES;
  localparam int CNT_W  = LOG2_SAMPLES + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1) << LOG2_SAMPLES;

  state_e              state_q, state_d;
  logic                drain_q, drain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                s0_valid_q, s0_valid_d;
  logic [OPER_W-1:0]   s0_x_q, s0_x_d;
  logic [OPER_W-1:0]   s0_y_q, s0_y_d;
  logic [PROD_W-1:0]   s0_z_q, s0_z_d;

  logic                s1_valid_q, s1_valid_d;
  diff_t               s1_q, s1_d;
  diff_t               s1_res;

  logic [ED_W-1:0]     sum_ed_q, sum_ed_d;
  logic [BIAS_W-1:0]   sum_bias_q, sum_bias_d;
  logic [PROD_W-1:0]   max_ed_q, max_ed_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                in_ready;
  logic                accept;
  logic                clear;

  assign in_ready     = (state_q == RUN) && (cnt_q < N_SAMPLES);
  assign smp.in_ready = in_ready;
  assign accept       = smp.in_valid && in_ready;

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign sum_ed   = sum_ed_q;
  assign sum_bias = $signed(sum_bias_q);
  assign max_ed   = max_ed_q;
  assign err_cnt  = err_cnt_q;

  am_abs_diff u_abs_diff (
    .x        (s0_x_q),
    .y        (s0_y_q),
    .z_approx (s0_z_q),
    .res      (s1_res)
  );

  always_comb begin
    // NOTE: every _d takes its held value first, so no path leaves a latch.
    state_d    = state_q;
    drain_d    = drain_q;
    cnt_d      = cnt_q;
    clear      = 1'b0;
    s0_valid_d = accept;
    s0_x_d     = s0_x_q;
    s0_y_d     = s0_y_q;
    s0_z_d     = s0_z_q;
    s1_valid_d = s0_valid_q;
    s1_d       = s1_q;
    sum_ed_d   = sum_ed_q;
    sum_bias_d = sum_bias_q;
    max_ed_d   = max_ed_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (accept && (cnt_q == N_SAMPLES - CNT_W'(1))) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        // Two cycles flush the capture and stage-1 registers.
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d  = cnt_q + CNT_W'(1);
      s0_x_d = smp.x;
      s0_y_d = smp.y;
      s0_z_d = smp.z_approx;
    end

    if (s0_valid_q) s1_d = s1_res;

    if (s1_valid_q) begin
      sum_ed_d   = sum_ed_q + ED_W'(s1_q.abs_diff);
      sum_bias_d = sum_bias_q + {{(BIAS_W-PROD_W-1){s1_q.sdiff[PROD_W]}}, s1_q.sdiff};
      if (s1_q.abs_diff > max_ed_q) max_ed_d = s1_q.abs_diff;
      if (s1_q.abs_diff != '0)      err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    if (clear) begin
      cnt_d      = '0;
      s0_valid_d = 1'b0;
      s1_valid_d = 1'b0;
      sum_ed_d   = '0;
      sum_bias_d = '0;
      max_ed_d   = '0;
      err_cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; all decisions live above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      s0_valid_q <= 1'b0;
      s0_x_q     <= '0;
      s0_y_q     <= '0;
      s0_z_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      sum_ed_q   <= '0;
      sum_bias_q <= '0;
      max_ed_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
      s0_valid_q <= s0_valid_d;
      s0_x_q     <= s0_x_d;
      s0_y_q     <= s0_y_d;
      s0_z_q     <= s0_z_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      sum_ed_q   <= sum_ed_d;
      sum_bias_q <= sum_bias_d;
      max_ed_q   <= max_ed_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_am_error_monitor.sv
// Directed bench for am_error_monitor: a 4-sample instance checked cycle by
// cycle through a scoreboard, and a full-size instance swept exhaustively.
module tb_am_error_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  always #5 clk = ~clk;

  am_error_monitor_if ifa ();
  am_error_monitor_if ifb ();

  logic               busy_a, done_a;
  logic [17:0]        ed_a;
  logic signed [18:0] bias_a;
  logic [15:0]        max_a;
  logic [2:0]         ec_a;

  logic               busy_b, done_b;
  logic [31:0]        ed_b;
  logic signed [32:0] bias_b;
  logic [15:0]        max_b;
  logic [16:0]        ec_b;

  am_error_monitor #(.LOG2_SAMPLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .smp(ifa),
    .busy(busy_a), .done(done_a), .sum_ed(ed_a), .sum_bias(bias_a),
    .max_ed(max_a), .err_cnt(ec_a)
  );

  am_error_monitor #(.LOG2_SAMPLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .smp(ifb),
    .busy(busy_b), .done(done_b), .sum_ed(ed_b), .sum_bias(bias_b),
    .max_ed(max_b), .err_cnt(ec_b)
  );

  typedef struct {
    int     due;
    longint ed;
    longint bias;
    longint mx;
    longint ec;
  } snap_t;

  snap_t  sb[$];
  snap_t  head;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     last_acc = 0;
  int     acc_b = 0;
  longint m_ed = 0, m_bias = 0, m_max = 0, m_ec = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted sample's running totals are due two edges later.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      head = sb.pop_front();
      chk("sb_due",  cyc, head.due);
      chk("sb_ed",   longint'(ed_a),   head.ed);
      chk("sb_bias", longint'(bias_a), head.bias);
      chk("sb_max",  longint'(max_a),  head.mx);
      chk("sb_ec",   longint'(ec_a),   head.ec);
    end
  end

  task automatic pulse_a(input bit clear_model);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    if (clear_model) begin
      m_ed = 0; m_bias = 0; m_max = 0; m_ec = 0;
    end
  endtask

  task automatic idle_a();
    @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z);
    longint d, a;
    int t = 0;
    ifa.x = x; ifa.y = y; ifa.z_approx = z; ifa.in_valid = 1'b1;
    while (!ifa.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_a", longint'(ifa.in_ready), 1);
    @(posedge clk);
    #1;
    d = longint'(z) - longint'(x) * longint'(y);
    a = (d < 0) ? -d : d;
    m_ed += a;
    m_bias += d;
    if (a > m_max) m_max = a;
    if (d != 0) m_ec++;
    sb.push_back('{due: cyc + 2, ed: m_ed, bias: m_bias, mx: m_max, ec: m_ec});
    last_acc = cyc;
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic wait_done_a();
    @(negedge clk);
    chk("drain_done_low", longint'(done_a), 0);
    chk("drain_busy",     longint'(busy_a), 1);
    chk("drain_ready",    longint'(ifa.in_ready), 0);
    @(negedge clk);
    chk("done_lat",       cyc - last_acc, 2);
    chk("done_high",      longint'(done_a), 1);
    chk("done_busy",      longint'(busy_a), 0);
  endtask

  task automatic chk_ref_run(input string tag);
    chk({tag, "_ed"},   longint'(ed_a),   69);
    chk({tag, "_bias"}, longint'(bias_a), 19);
    chk({tag, "_max"},  longint'(max_a),  44);
    chk({tag, "_ec"},   longint'(ec_a),   2);
  endtask

  task automatic ref_run();
    send_a(8'd3,   8'd5,   16'd15);
    send_a(8'd255, 8'd255, 16'd65000);
    send_a(8'd0,   8'd7,   16'd0);
    send_a(8'd16,  8'd16,  16'd300);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.z_approx = '0;
    ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.z_approx = '0;

    // Reset values
    #1;
    chk("rst_busy",  longint'(busy_a), 0);
    chk("rst_done",  longint'(done_a), 0);
    chk("rst_ready", longint'(ifa.in_ready), 0);
    chk("rst_ed",    longint'(ed_a), 0);
    chk("rst_ec",    longint'(ec_a), 0);
    chk("rst_done_b", longint'(done_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid while idle is ignored
    ifa.x = 8'd1; ifa.y = 8'd1; ifa.z_approx = 16'd5; ifa.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    ifa.in_valid = 1'b0;
    chk("idle_ec",    longint'(ec_a), 0);
    chk("idle_ready", longint'(ifa.in_ready), 0);

    // Reference run, back-to-back samples
    pulse_a(1'b1);
    chk("run_busy",  longint'(busy_a), 1);
    chk("run_ready", longint'(ifa.in_ready), 1);
    ref_run();
    wait_done_a();
    chk_ref_run("ref");
    idle_a();
    chk("done_hold", longint'(done_a), 1);

    // Start from DONE clears; gapped valid; start during RUN ignored
    pulse_a(1'b1);
    chk("clr_busy", longint'(busy_a), 1);
    chk("clr_ed",   longint'(ed_a), 0);
    chk("clr_bias", longint'(bias_a), 0);
    chk("clr_max",  longint'(max_a), 0);
    chk("clr_ec",   longint'(ec_a), 0);
    send_a(8'd3, 8'd5, 16'd15);
    idle_a();
    send_a(8'd255, 8'd255, 16'd65000);
    pulse_a(1'b0);
    chk("run_start_busy", longint'(busy_a), 1);
    send_a(8'd0, 8'd7, 16'd0);
    idle_a();
    send_a(8'd16, 8'd16, 16'd300);
    wait_done_a();
    chk_ref_run("gap");

    // Largest possible error magnitude
    pulse_a(1'b1);
    send_a(8'd0, 8'd0, 16'hFFFF);
    send_a(8'd1, 8'd1, 16'd1);
    send_a(8'd2, 8'd3, 16'd6);
    send_a(8'd9, 8'd9, 16'd81);
    wait_done_a();
    chk("big_max",  longint'(max_a),  65535);
    chk("big_bias", longint'(bias_a), 65535);
    chk("big_ec",   longint'(ec_a),   1);

    // Asynchronous reset mid-run
    pulse_a(1'b1);
    send_a(8'd255, 8'd255, 16'd65000);
    send_a(8'd16, 8'd16, 16'd300);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_busy",  longint'(busy_a), 0);
    chk("arst_done",  longint'(done_a), 0);
    chk("arst_ready", longint'(ifa.in_ready), 0);
    chk("arst_ed",    longint'(ed_a), 0);
    chk("arst_bias",  longint'(bias_a), 0);
    chk("arst_max",   longint'(max_a), 0);
    chk("arst_ec",    longint'(ec_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", longint'(busy_a), 0);
    pulse_a(1'b1);
    ref_run();
    wait_done_a();
    chk_ref_run("after_rst");

    // Exhaustive sweep with an exact multiplier on the full-size instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ifb.x = i[15:8];
      ifb.y = i[7:0];
      ifb.z_approx = 16'(ifb.x) * 16'(ifb.y);
      ifb.in_valid = 1'b1;
      #1;
      if (ifb.in_ready) acc_b++;
      @(negedge clk);
    end
    ifb.in_valid = 1'b0;
    chk("ex_ready_after", longint'(ifb.in_ready), 0);
    repeat (2) @(negedge clk);
    chk("ex_accepts", acc_b, 65536);
    chk("ex_done",    longint'(done_b), 1);
    chk("ex_ready",   longint'(ifb.in_ready), 0);
    chk("ex_ed",      longint'(ed_b), 0);
    chk("ex_bias",    longint'(bias_b), 0);
    chk("ex_max",     longint'(max_b), 0);
    chk("ex_ec",      longint'(ec_b), 0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/am_error_monitor.md
AM_ERROR_MONITOR -- requirements
Module: am_error_monitor

Interface
REQ-001 Parameter LOG2_SAMPLES, default 16: log2 of samples per run; 16 covers the full 8x8 input space.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port start  input  1  one-cycle pulse; begins a run.
REQ-005 Port in_valid  input  1  sample present on x, y and z_approx.
REQ-006 Port in_ready  output  1  monitor accepts a sample this cycle.
REQ-007 Port x  input  8  unsigned multiplicand driven to the approximate multiplier.
REQ-008 Port y  input  8  unsigned multiplier driven to the approximate multiplier.
REQ-009 Port z_approx  input  16  product returned by the approximate multiplier for x, y.
REQ-010 Port busy  output  1  high in RUN and DRAIN.
REQ-011 Port done  output  1  high in DONE; results valid.
REQ-012 Port sum_ed  output  16+LOG2_SAMPLES  sum of |x*y - z_approx|.
REQ-013 Port sum_bias  output  17+LOG2_SAMPLES  signed two's-complement sum of (z_approx - x*y).
REQ-014 Port max_ed  output  16  largest |x*y - z_approx| in the run.
REQ-015 Port err_cnt  output  LOG2_SAMPLES+1  number of samples with nonzero error.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE or DONE, start SHALL clear all accumulators and the sample counter and enter RUN on the next cycle.
REQ-018 start in RUN or DRAIN SHALL be ignored.
REQ-019 in_ready SHALL be high only in RUN while accepted samples < 2^LOG2_SAMPLES.
REQ-020 A sample SHALL be accepted exactly when in_valid and in_ready are both high; in_valid outside RUN SHALL be ignored.
REQ-021 Stage 1 SHALL register the exact 16-bit product x*y, the 16-bit unsigned absolute difference and a 17-bit signed difference for each accepted sample.
REQ-022 Stage 2 SHALL add the stage-1 results to sum_ed and sum_bias, update max_ed when greater, and increment err_cnt when the difference is nonzero.
REQ-023 A sample accepted in cycle n SHALL be reflected in the outputs at the end of cycle n+2.
REQ-024 The monitor SHALL enter DRAIN in the cycle after the final sample is accepted.
REQ-025 DRAIN SHALL last exactly 2 cycles and then enter DONE.
REQ-026 done SHALL go high 3 cycles after the final acceptance and stay high until start.
REQ-027 The accumulator widths SHALL make overflow impossible; no wrap-around and no saturation are required.
REQ-028 max_ed SHALL use strictly-greater comparison, so ties leave it unchanged.
REQ-029 Gaps in in_valid SHALL stall only acceptance; they SHALL NOT corrupt the pipeline.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE.
REQ-031 While rst_n is low, the pipeline registers, counters and accumulators SHALL be 0.
REQ-032 While rst_n is low, outputs in_ready, busy and done SHALL be 0.
REQ-033 Reset mid-run SHALL abort the run immediately and discard all partial results.

Structure
REQ-034 Package am_eval_pkg SHALL hold the FSM state enum, the product width (16) and the operand width (8).
REQ-035 Stage 1 SHALL be the sub-module am_abs_diff: combinational exact product, absolute difference and signed difference.
REQ-036 The FSM, sample counter, pipeline registers and accumulators SHALL reside in am_error_monitor.

Verification
REQ-037 LOG2_SAMPLES=2; samples (3,5,15),(255,255,65000),(0,7,0),(16,16,300) -> sum_ed=25+44=69, sum_bias=-25+44=19, max_ed=44, err_cnt=2, done 3 cycles after the 4th accept.
REQ-038 LOG2_SAMPLES=16; exhaustive x,y with z_approx=x*y -> all results 0, done high, in_ready low after 65536 accepts.
REQ-039 in_valid toggled every other cycle with the REQ-037 data -> identical results; done follows the last accept by 3 cycles.
REQ-040 start pulsed during RUN -> ignored, counts unaffected; start in DONE -> all results cleared next cycle, busy=1.
REQ-041 rst_n low after 2 accepts -> outputs 0 asynchronously, FSM in IDLE; next run from start gives REQ-037 results.
REQ-042 z_approx=65535 with x=y=0 -> max_ed=65535, sum_bias=+65535.
